// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard unit for the pipelined MIPS core.
// It drives the EX operand forwarding selects and detects load-use hazards.
// A per-register countdown scoreboard stalls ID while a multicycle result
// (mult/div) is still outstanding.
module fwd_hazard_scoreboard #(
  parameter int  ADDR_W     = 5,
  parameter int  NUM_SRC    = 2,
  parameter int  NUM_STAGES = 2,
  parameter int  LAT_W      = 4,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_addr,
  input  logic [NUM_STAGES*ADDR_W-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0]       stg_regwrite,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [ADDR_W-1:0]           id_rd,
  input  logic                        id_regwrite,
  input  logic [ADDR_W-1:0]           ex_rd,
  input  logic                        ex_mem_read,
  input  logic                        issue_mc,
  input  logic [LAT_W-1:0]            issue_lat,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic [1:0]                  stall_cause,
  output logic [31:0]                 stall_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // The whole busy vector is needed every cycle, so the counters live in flops.
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [31:0]         stall_count_q;
  logic [31:0]         stall_count_d;
  logic                load_use;
  logic                sb_raw;
  logic                sb_waw;
  logic                issue_accept;

  genvar gi;

  // Per-operand forwarding: walk from the farthest stage inward so the nearest match wins.
  for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    logic [ADDR_W-1:0] src;
    logic [SEL_W-1:0]  sel;

    assign src = ex_src_addr[gi*ADDR_W +: ADDR_W];

    // Select the lowest-numbered stage that writes this operand's register.
    always_comb begin
      sel = '0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (stg_regwrite[k-1] && (stg_rd[(k-1)*ADDR_W +: ADDR_W] != '0) &&
            (stg_rd[(k-1)*ADDR_W +: ADDR_W] == src)) begin
          sel = SEL_W'(k);
        end
      end
    end

    assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
  end

  // A register is busy while its countdown has not reached zero.
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    assign busy[gi] = (cnt_q[gi] != '0);
  end

  // Hazard detection against the EX load and against outstanding multicycle writes.
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src_addr[i*ADDR_W +: ADDR_W] == ex_rd)) begin
        load_use = 1'b1;
      end
      if (id_src_used[i] && (id_src_addr[i*ADDR_W +: ADDR_W] != '0) &&
          busy[id_src_addr[i*ADDR_W +: ADDR_W]]) begin
        sb_raw = 1'b1;
      end
    end
    load_use = load_use && ex_mem_read && (ex_rd != '0);
    sb_waw   = id_regwrite && (id_rd != '0) && busy[id_rd];
  end

  assign stall_cause  = {sb_raw | sb_waw, load_use};
  assign stall        = |stall_cause;
  assign issue_accept = issue_mc && !stall;

  // Next counter values: count down, and a fresh issue overrides an expiring entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
      if (r != 0) begin
        if (busy[r]) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        if (issue_accept && (id_rd == ADDR_W'(r)) && (issue_lat != '0)) begin
          cnt_d[r] = issue_lat;
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // State update; reset also discards any issue presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard.
// Each cycle the expected outputs, taken from a small behavioural model, are
// queued when stimulus is applied and popped and compared at the falling edge.
module tb_fwd_hazard_scoreboard;

  localparam int ADDR_W     = 5;
  localparam int NUM_SRC    = 2;
  localparam int NUM_STAGES = 2;
  localparam int LAT_W      = 4;
  localparam int SEL_W      = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_SRC*ADDR_W-1:0]    ex_src_addr;
  logic [NUM_STAGES*ADDR_W-1:0] stg_rd;
  logic [NUM_STAGES-1:0]        stg_regwrite;
  logic [NUM_SRC*ADDR_W-1:0]    id_src_addr;
  logic [NUM_SRC-1:0]           id_src_used;
  logic [ADDR_W-1:0]            id_rd;
  logic                         id_regwrite;
  logic [ADDR_W-1:0]            ex_rd;
  logic                         ex_mem_read;
  logic                         issue_mc;
  logic [LAT_W-1:0]             issue_lat;
  logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
  logic                         stall;
  logic [1:0]                   stall_cause;
  logic [31:0]                  stall_count;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst(rst), .ex_src_addr(ex_src_addr), .stg_rd(stg_rd),
    .stg_regwrite(stg_regwrite), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .issue_mc(issue_mc), .issue_lat(issue_lat), .fwd_sel(fwd_sel), .stall(stall),
    .stall_cause(stall_cause), .stall_count(stall_count)
  );

  typedef struct {
    string       tag;
    logic [3:0]  fwd;
    logic        stall;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state.
  int          m_cnt [32];
  logic [31:0] m_stall_count = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [SEL_W-1:0] m_fwd(input int i);
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] rd;
    src = ex_src_addr[i*ADDR_W +: ADDR_W];
    for (int k = 1; k <= NUM_STAGES; k++) begin
      rd = stg_rd[(k-1)*ADDR_W +: ADDR_W];
      if (stg_regwrite[k-1] && rd != 0 && rd == src) return SEL_W'(k);
    end
    return '0;
  endfunction

  // One clock cycle: queue expectations, compare at negedge, advance the model.
  task automatic cycle(input string tag);
    exp_t        e;
    exp_t        g;
    logic        lu;
    logic        sb;
    logic [ADDR_W-1:0] a;
    lu = 1'b0;
    sb = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = id_src_addr[i*ADDR_W +: ADDR_W];
      if (id_src_used[i] && ex_mem_read && ex_rd != 0 && a == ex_rd) lu = 1'b1;
      if (id_src_used[i] && a != 0 && m_cnt[a] != 0) sb = 1'b1;
    end
    if (id_regwrite && id_rd != 0 && m_cnt[id_rd] != 0) sb = 1'b1;
    e.tag   = tag;
    e.fwd   = {m_fwd(1), m_fwd(0)};
    e.cause = {sb, lu};
    e.stall = sb | lu;
    e.cnt   = m_stall_count;
    exp_q.push_back(e);

    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check({g.tag, "_fwd"},   32'(fwd_sel),     32'(g.fwd));
      check({g.tag, "_stall"}, 32'(stall),       32'(g.stall));
      check({g.tag, "_cause"}, 32'(stall_cause), 32'(g.cause));
      check({g.tag, "_count"}, stall_count,      g.cnt);
      $display("txn %s fwd=%0h stall=%0d cause=%0b count=%0d", g.tag, fwd_sel, stall,
               stall_cause, stall_count);
    end

    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_stall_count = 32'd0;
    end else begin
      for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) m_cnt[r] = m_cnt[r] - 1;
      if (issue_mc && !e.stall && id_rd != 0 && issue_lat != 0) m_cnt[id_rd] = int'(issue_lat);
      if (e.stall && m_stall_count != 32'hFFFF_FFFF) m_stall_count = m_stall_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_src_addr  = '0;
    stg_rd       = '0;
    stg_regwrite = '0;
    id_src_addr  = '0;
    id_src_used  = '0;
    id_rd        = '0;
    id_regwrite  = 1'b0;
    ex_rd        = '0;
    ex_mem_read  = 1'b0;
    issue_mc     = 1'b0;
    issue_lat    = '0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle("reset");
    rst = 1'b0;

    // Forwarding: both stages hit op0, nearest wins; op1 has no match.
    stg_rd = {5'd8, 5'd8}; stg_regwrite = 2'b11; ex_src_addr = {5'd9, 5'd8};
    cycle("fwd_both");
    // Stage 2 only (stage 1 has the register but no RegWrite).
    stg_rd = {5'd5, 5'd5}; stg_regwrite = 2'b10; ex_src_addr = {5'd0, 5'd5};
    cycle("fwd_stg2");
    stg_rd = {5'd0, 5'd0}; stg_regwrite = 2'b11; ex_src_addr = {5'd0, 5'd0};
    cycle("fwd_zero");
    idle_inputs();

    // Load-use with a multicycle issue attempted during the stall.
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
    issue_mc = 1'b1; id_rd = 5'd12; issue_lat = 4'd5;
    cycle("loaduse");
    issue_mc = 1'b0;
    id_src_used = 2'b00;
    cycle("loaduse_unused");
    idle_inputs();
    id_src_addr = {5'd12, 5'd0}; id_src_used = 2'b10;
    cycle("ignored_issue");
    idle_inputs();

    // Multicycle RAW, counted from a fresh reset.
    rst = 1'b1;
    cycle("rst_before_raw");
    rst = 1'b0;
    issue_mc = 1'b1; id_rd = 5'd10; id_regwrite = 1'b1; issue_lat = 4'd4;
    cycle("raw_issue");
    idle_inputs();
    id_src_addr = {5'd0, 5'd10}; id_src_used = 2'b01;
    for (int c = 1; c <= 5; c++) cycle($sformatf("raw_t%0d", c));
    check("raw_total", stall_count, 32'd4);
    idle_inputs();

    // Re-issue to r12 exactly as its counter expires.
    issue_mc = 1'b1; id_rd = 5'd12; issue_lat = 4'd5;
    cycle("exp_issue1");
    idle_inputs();
    for (int c = 0; c < 4; c++) cycle($sformatf("exp_wait%0d", c));
    issue_mc = 1'b1; id_rd = 5'd12; issue_lat = 4'd5;
    cycle("exp_reissue");
    idle_inputs();
    id_src_addr = {5'd12, 5'd0}; id_src_used = 2'b10;
    for (int c = 0; c < 6; c++) cycle($sformatf("exp_read%0d", c));
    idle_inputs();

    // WAW, then reset in the middle of the countdown.
    issue_mc = 1'b1; id_rd = 5'd7; id_regwrite = 1'b1; issue_lat = 4'd6;
    cycle("waw_issue");
    issue_mc = 1'b0;
    for (int c = 0; c < 3; c++) cycle($sformatf("waw_stall%0d", c));
    rst = 1'b1;
    cycle("waw_rst");
    rst = 1'b0;
    cycle("waw_after_rst");
    check("waw_count_cleared", stall_count, 32'd0);
    idle_inputs();

    // An issue presented during reset must be dropped.
    rst = 1'b1; issue_mc = 1'b1; id_rd = 5'd4; issue_lat = 4'd3;
    cycle("rst_issue");
    rst = 1'b0; issue_mc = 1'b0;
    id_src_addr = {5'd0, 5'd4}; id_src_used = 2'b01;
    cycle("rst_issue_gone");
    idle_inputs();

    // Random traffic over a small register range.
    for (int n = 0; n < 300; n++) begin
      ex_src_addr  = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
      stg_rd       = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
      stg_regwrite = 2'($urandom_range(0, 3));
      id_src_addr  = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
      id_src_used  = 2'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 5));
      id_regwrite  = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 5));
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      issue_mc     = ($urandom_range(0, 2) == 0);
      issue_lat    = 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 60) == 0);
      cycle($sformatf("rand%0d", n));
    end
    rst = 1'b0;

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised next-generation forwarding and hazard unit for the pipelined MIPS core.
- Generates per-operand forwarding selects for the EX stage across NUM_STAGES downstream pipeline stages.
- Detects load-use hazards against the instruction in EX.
- Tracks outstanding multicycle (mult/div) destination registers in a per-register countdown scoreboard and stalls ID on RAW/WAW conflicts.
- Sits beside the ID/EX pipeline register and drives the EX operand muxes, the PC/IF-ID write enables and the ID/EX bubble insert.

Parameters:
- ADDR_W, 5: register address width; the scoreboard has 2**ADDR_W entries.
- NUM_SRC, 2: source operands per instruction (rs, rt, ...).
- NUM_STAGES, 2: forwarding stages after EX; stage 1 = EX/MEM, stage 2 = MEM/WB, and so on.
- LAT_W, 4: width of the multicycle latency field and of each scoreboard counter.
- SEL_W, derived as clog2(NUM_STAGES+1): width of one forwarding select.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_src_addr  in  NUM_SRC*ADDR_W  source registers of the instruction in EX; operand i in bits [i*ADDR_W +: ADDR_W]
- stg_rd  in  NUM_STAGES*ADDR_W  destination register of each forwarding stage; stage k in slice k-1
- stg_regwrite  in  NUM_STAGES  RegWrite of each forwarding stage
- id_src_addr  in  NUM_SRC*ADDR_W  source registers of the instruction in ID
- id_src_used  in  NUM_SRC  the ID instruction actually reads operand i
- id_rd  in  ADDR_W  destination register of the ID instruction
- id_regwrite  in  1  the ID instruction writes id_rd
- ex_rd  in  ADDR_W  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- issue_mc  in  1  the ID instruction is multicycle and leaves ID this cycle
- issue_lat  in  LAT_W  cycles until its result is in the register file
- fwd_sel  out  NUM_SRC*SEL_W  per-operand select: 0 = register file, k = stage k
- stall  out  1  freeze PC and IF/ID, bubble ID/EX
- stall_cause  out  2  bit0 = load-use, bit1 = scoreboard
- stall_count  out  32  saturating count of stalled cycles

Behaviour:
- fwd_sel is combinational.
  - For each operand i, pick the lowest k with stg_regwrite[k-1]=1, stg_rd[k-1]!=0 and stg_rd[k-1]==ex_src_addr[i].
  - If no stage matches, fwd_sel is 0.
  - The nearest stage always wins; operands are resolved independently.
- Load-use hazard (combinational): ex_mem_read=1, ex_rd!=0, and for some i, id_src_used[i]=1 and id_src_addr[i]==ex_rd. Asserts cause bit0.
- Scoreboard: cnt[r] is LAT_W bits per register; busy[r] = (cnt[r]!=0).
- Scoreboard hazard (combinational): raised if either condition holds. Asserts cause bit1.
  - Some used id_src_addr[i]!=0 has busy=1 (RAW).
  - id_regwrite=1, id_rd!=0 and busy[id_rd]=1 (WAW).
- stall = OR of stall_cause bits. Both cause bits may be 1 simultaneously.
- Issue is accepted only when issue_mc=1 and stall=0.
  - On acceptance with id_rd!=0 and issue_lat!=0: cnt[id_rd] <= issue_lat on the next edge.
  - issue_lat=0 or id_rd=0: no scoreboard entry is created.
- Every other nonzero counter decrements by 1 each cycle.
  - A reader stalled on r leaves ID in the cycle after cnt[r] reaches 0. The register file is write-before-read, so no forwarding is needed for multicycle results.
- Issue to r in the same cycle that cnt[r] is 1 (expiring): the issue load wins.
- cnt[0] is hard-wired to 0.
- stall_count increments on every cycle with stall=1 and holds at 32'hFFFF_FFFF.
- Reset (synchronous, any cycle, including mid-countdown): all cnt <= 0, stall_count <= 0.
  - Outputs are then purely combinational from the inputs: fwd_sel follows the inputs, and stall is 0 unless a load-use hazard is present on the inputs.
  - A pending issue in the reset cycle is discarded.
- Latency:
  - Forwarding and stall: 0 cycles (same cycle).
  - Scoreboard set: visible 1 cycle after acceptance.

Test Plan:
- Both stages: stg_rd={8,8}, both regwrite=1, ex_src_addr={8,9} -> fwd_sel op0=1 (nearest), op1=0.
- Stage 2 only, register zero: stg_rd[1]=5, regwrite=1, ex src 5 -> sel=2; repeat with rd=0 -> sel=0.
- Load-use: ex_mem_read=1, ex_rd=3, id src0=3 used -> stall=1, cause=01 for one cycle; same with id_src_used=0 -> stall=0.
- Multicycle RAW: issue rd=10 lat=4 at cycle t; ID reads 10 from t+1 -> stall=1, cause=10 in cycles t+1..t+4, stall=0 at t+5; stall_count=4.
- WAW plus reset mid-operation: issue rd=7 lat=6; ID writes 7 -> stall; assert rst at count 3 -> next cycle stall=0 and stall_count=0.
- Simultaneous events: issue rd=12 lat=5 in the cycle cnt[12]=1 -> cnt[12]=5 next cycle. Issue while load-use stall is active -> ignored, no scoreboard entry.
